mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the fetch requester (PC_gen/Insmem side)
//  and the load/store requester (ALU/DataMem side) of the RV32I core.
//  Arbitrates between the two, sequences each memory access through a fixed-latency memory,
//  and returns a registered one-cycle ack with read data to the winner.
//  Data wins by default; a starvation guard forces a fetch grant after STARVE_MAX consecutive data wins.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (byte enables are DW/8 wide)
//  MEM_LAT     1   cycles from mem_en high to mem_rdata valid (>=1)
//  STARVE_MAX  4   consecutive data grants allowed while i_req is pending (>=1)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  i_req      in   1     fetch request (level)
//  i_addr     in   AW    fetch address
//  i_ack      out  1     fetch done, 1-cycle pulse
//  i_rdata    out  DW    fetch data, valid with i_ack, held until next fetch ack
//  d_req      in   1     load/store request (level)
//  d_we       in   1     1=store, 0=load
//  d_be       in   DW/8  store byte enables
//  d_addr     in   AW    data address
//  d_wdata    in   DW    store data
//  d_ack      out  1     data done, 1-cycle pulse
//  d_rdata    out  DW    load data, valid with d_ack, held until next load ack
//  mem_en     out  1     memory access strobe, 1 cycle per transaction
//  mem_we     out  1     memory write enable
//  mem_be     out  DW/8  memory byte enables
//  mem_addr   out  AW    memory address
//  mem_wdata  out  DW    memory write data
//  mem_rdata  in   DW    memory read data
//  busy       out  1     1 when state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; starve_cnt=0.
//   - All outputs 0: i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy.
//   - Reset mid-transaction aborts it. No ack is issued for the aborted transaction.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   - IDLE: req inputs are sampled only here.
//     - If no req: stay in IDLE.
//     - Else pick a winner, register owner and the mem_* fields, go to ISSUE.
//   - ISSUE: mem_en=1 for exactly this cycle. wait_cnt loads MEM_LAT-1. Go to WAIT.
//   - WAIT: stay while wait_cnt!=0, decrementing each cycle.
//     - Leaving WAIT at the cycle where mem_rdata is valid (ISSUE cycle + MEM_LAT), capture mem_rdata into the owner's rdata register if the access is a read.
//     - Go to RESP.
//   - RESP: owner's ack=1 for one cycle. Go to IDLE.
//  Timing:
//   - Request seen in IDLE at cycle 0 -> mem_en at cycle 1 -> ack at cycle 2+MEM_LAT.
//   - Next IDLE sample at cycle 3+MEM_LAT.
//   - req still high the cycle after ack is a new request.
//  Field mapping:
//   - Fetch: mem_we=0, mem_be=all ones, mem_addr=i_addr.
//   - Data: mem_we=d_we, mem_be=d_be, mem_addr=d_addr, mem_wdata=d_wdata.
//   - Addresses are passed unaltered, with no alignment check.
//   - mem_we/be/addr/wdata hold their value through WAIT/RESP/IDLE until the next grant.
//   - mem_we is meaningful only while mem_en=1.
//  Store ack: d_ack pulses with normal timing. d_rdata is unchanged by a store.
//  Arbitration in IDLE:
//   - Only one req: that requester wins.
//   - Both req: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
//  starve_cnt update:
//   - +1, saturating at STARVE_MAX, on a data grant while i_req=1.
//   - Cleared on any fetch grant, or when IDLE samples i_req=0.
//  Protocol violations:
//   - Requester must hold req and its fields stable until its ack. Fields are latched at grant, so later changes are ignored.
//   - req dropped before ack: the transaction still completes and the ack still pulses.
//  i_ack and d_ack are never high in the same cycle.
// TESTING
//  1 Reset: assert rst=0 during WAIT of a fetch -> all outputs 0 immediately; after release with reqs low, no ack and busy=0.
//  2 Fetch, MEM_LAT=1: i_req=1, i_addr=0x10 at cycle 0; mem_rdata=0x00500093 at cycle 2
//    -> mem_en=1, mem_we=0, mem_be=4'hF, mem_addr=0x10 at cycle 1; i_ack=1, i_rdata=0x00500093 at cycle 3.
//  3 Store: d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF
//    -> at cycle 1 mem_en=1, mem_we=1, mem_be=4'b0011, mem_addr=0x100, mem_wdata=0xDEADBEEF;
//    -> d_ack=1 at cycle 3; d_rdata keeps its prior value.
//  4 Starvation, STARVE_MAX=4: i_req and d_req held high -> grant order D,D,D,D,I,D,D,D,D,I; never two acks in one cycle.
//  5 Back-to-back: d_req held high, MEM_LAT=1 -> mem_en every 4 cycles (cycles 1,5,9), d_ack at cycles 3,7,11.
//  6 MEM_LAT=3 load of 0x12345678 at cycle 4 -> mem_en at cycle 1, d_ack with d_rdata=0x12345678 at cycle 5, busy=1 for cycles 1-5.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side buses of the shared memory port.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_ack;
    logic [DW-1:0]     i_rdata;

    logic              d_req;
    logic              d_we;
    logic [DW/8-1:0]   d_be;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic              d_ack;
    logic [DW-1:0]     d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_ack, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency single-port memory between fetch and load/store requesters.
// Latency: request sampled in IDLE at cycle 0 -> mem_en at cycle 1 -> ack at cycle 2+MEM_LAT.
// Backpressure: level requests are held by the requester until its one-cycle ack; no queueing.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_cmd_t;

    state_t         state, state_nxt;
    mem_cmd_t       cmd;
    logic           owner_i;
    logic           grant_i, grant_d;
    logic [WW-1:0]  wait_cnt;
    logic [SW-1:0]  starve_cnt;
    logic [DW-1:0]  i_rdata_q, d_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_nxt = ISSUE;
                    // Data is preferred unless fetch has been passed over STARVE_MAX times.
                    if (bus.i_req && (!bus.d_req || starve_cnt == SW'(STARVE_MAX)))
                        grant_i = 1'b1;
                    else
                        grant_d = 1'b1;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd        <= '0;
            owner_i    <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        owner_i  <= 1'b1;
                        cmd.we   <= 1'b0;
                        cmd.be   <= '1;
                        cmd.addr <= bus.i_addr;
                    end else if (grant_d) begin
                        owner_i   <= 1'b0;
                        cmd.we    <= bus.d_we;
                        cmd.be    <= bus.d_be;
                        cmd.addr  <= bus.d_addr;
                        cmd.wdata <= bus.d_wdata;
                    end
                    if (grant_i || !bus.i_req)
                        starve_cnt <= '0;
                    else if (grant_d && starve_cnt != SW'(STARVE_MAX))
                        starve_cnt <= starve_cnt + 1'b1;
                end
                ISSUE: wait_cnt <= WW'(MEM_LAT - 1);
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (!cmd.we) begin
                        // Last WAIT cycle is exactly when the memory presents read data.
                        if (owner_i) i_rdata_q <= bus.mem_rdata;
                        else         d_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = cmd.we;
    assign bus.mem_be    = cmd.be;
    assign bus.mem_addr  = cmd.addr;
    assign bus.mem_wdata = cmd.wdata;
    assign bus.i_ack     = (state == RESP) &&  owner_i;
    assign bus.d_ack     = (state == RESP) && !owner_i;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) ifa ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) ifb ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifa.i_req = 0; ifa.i_addr = 0; ifa.d_req = 0; ifa.d_we = 0; ifa.d_be = 0;
        ifa.d_addr = 0; ifa.d_wdata = 0; ifa.mem_rdata = 32'hBAD0BAD0;
        ifb.i_req = 0; ifb.i_addr = 0; ifb.d_req = 0; ifb.d_we = 0; ifb.d_be = 0;
        ifb.d_addr = 0; ifb.d_wdata = 0; ifb.mem_rdata = 32'hBAD0BAD0;
    endtask

    task automatic test_reset;
        logic [136:0] outs_a, outs_b;
        idle_inputs();
        rst = 0;
        tick(); tick();
        outs_a = {ifa.i_ack, ifa.d_ack, ifa.i_rdata, ifa.d_rdata, ifa.mem_en, ifa.mem_we,
                  ifa.mem_be, ifa.mem_addr, ifa.mem_wdata, ifa.busy};
        outs_b = {ifb.i_ack, ifb.d_ack, ifb.i_rdata, ifb.d_rdata, ifb.mem_en, ifb.mem_we,
                  ifb.mem_be, ifb.mem_addr, ifb.mem_wdata, ifb.busy};
        checks++; if (outs_a !== '0) begin failures++; $display("FAIL reset_outs_a got=%h exp=0", outs_a); end
        checks++; if (outs_b !== '0) begin failures++; $display("FAIL reset_outs_b got=%h exp=0", outs_b); end
        rst = 1;
        tick();
        // Start a fetch and pull reset while it sits in WAIT.
        ifa.i_req = 1; ifa.i_addr = 32'h44;
        tick();
        checks++; if (ifa.mem_addr !== 32'h44) begin failures++; $display("FAIL rst_pre_addr got=%h exp=44", ifa.mem_addr); end
        tick();
        checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", ifa.busy); end
        rst = 0;
        #1;
        outs_a = {ifa.i_ack, ifa.d_ack, ifa.i_rdata, ifa.d_rdata, ifa.mem_en, ifa.mem_we,
                  ifa.mem_be, ifa.mem_addr, ifa.mem_wdata, ifa.busy};
        checks++; if (outs_a !== '0) begin failures++; $display("FAIL rst_mid_outs got=%h exp=0", outs_a); end
        ifa.i_req = 0;
        tick();
        rst = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (ifa.i_ack !== 1'b0 || ifa.busy !== 1'b0) begin
                failures++; $display("FAIL rst_after c=%0d i_ack=%b busy=%b exp=0,0", c, ifa.i_ack, ifa.busy);
            end
        end
    endtask

    task automatic test_fetch;
        ifa.i_req = 1; ifa.i_addr = 32'h10;
        tick();
        checks++;
        if ({ifa.mem_en, ifa.mem_we, ifa.mem_be, ifa.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
            failures++; $display("FAIL fetch_issue en=%b we=%b be=%h addr=%h exp=1,0,f,10",
                                 ifa.mem_en, ifa.mem_we, ifa.mem_be, ifa.mem_addr);
        end
        tick();
        ifa.mem_rdata = 32'h00500093;
        checks++; if (ifa.mem_en !== 1'b0) begin failures++; $display("FAIL fetch_en_c2 got=%b exp=0", ifa.mem_en); end
        tick();
        ifa.mem_rdata = 32'hBAD0BAD0;
        checks++;
        if (ifa.i_ack !== 1'b1 || ifa.d_ack !== 1'b0 || ifa.i_rdata !== 32'h00500093) begin
            failures++; $display("FAIL fetch_ack i_ack=%b d_ack=%b i_rdata=%h exp=1,0,00500093",
                                 ifa.i_ack, ifa.d_ack, ifa.i_rdata);
        end
        ifa.i_req = 0;
        tick();
        checks++;
        if (ifa.i_ack !== 1'b0 || ifa.busy !== 1'b0 || ifa.i_rdata !== 32'h00500093) begin
            failures++; $display("FAIL fetch_after i_ack=%b busy=%b i_rdata=%h exp=0,0,00500093",
                                 ifa.i_ack, ifa.busy, ifa.i_rdata);
        end
    endtask

    task automatic test_load;
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_be = 4'hF; ifa.d_addr = 32'h80; ifa.d_wdata = 32'h0;
        tick();
        checks++;
        if ({ifa.mem_en, ifa.mem_we, ifa.mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
            failures++; $display("FAIL load_issue en=%b we=%b addr=%h exp=1,0,80", ifa.mem_en, ifa.mem_we, ifa.mem_addr);
        end
        tick();
        ifa.mem_rdata = 32'hCAFEF00D;
        tick();
        ifa.mem_rdata = 32'hBAD0BAD0;
        checks++;
        if (ifa.d_ack !== 1'b1 || ifa.i_ack !== 1'b0 || ifa.d_rdata !== 32'hCAFEF00D || ifa.i_rdata !== 32'h00500093) begin
            failures++; $display("FAIL load_ack d_ack=%b i_ack=%b d_rdata=%h i_rdata=%h exp=1,0,cafef00d,00500093",
                                 ifa.d_ack, ifa.i_ack, ifa.d_rdata, ifa.i_rdata);
        end
        ifa.d_req = 0;
        tick();
    endtask

    task automatic test_store;
        ifa.d_req = 1; ifa.d_we = 1; ifa.d_be = 4'b0011; ifa.d_addr = 32'h100; ifa.d_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if ({ifa.mem_en, ifa.mem_we, ifa.mem_be, ifa.mem_addr, ifa.mem_wdata} !==
            {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF}) begin
            failures++; $display("FAIL store_issue en=%b we=%b be=%h addr=%h wdata=%h exp=1,1,3,100,deadbeef",
                                 ifa.mem_en, ifa.mem_we, ifa.mem_be, ifa.mem_addr, ifa.mem_wdata);
        end
        tick();
        ifa.mem_rdata = 32'h55555555;
        tick();
        ifa.mem_rdata = 32'hBAD0BAD0;
        checks++;
        if (ifa.d_ack !== 1'b1 || ifa.i_ack !== 1'b0 || ifa.d_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL store_ack d_ack=%b i_ack=%b d_rdata=%h exp=1,0,cafef00d",
                                 ifa.d_ack, ifa.i_ack, ifa.d_rdata);
        end
        ifa.d_req = 0; ifa.d_we = 0;
        tick();
    endtask

    task automatic test_starvation;
        int got[10];
        int exp_i[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int n = 0;
        int dual = 0;
        ifa.i_req = 1; ifa.i_addr = 32'h20;
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_be = 4'hF; ifa.d_addr = 32'h300;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick();
            if (ifa.i_ack && ifa.d_ack) dual++;
            if (ifa.i_ack) begin got[n] = 1; n++; end
            else if (ifa.d_ack) begin got[n] = 0; n++; end
        end
        ifa.i_req = 0; ifa.d_req = 0;
        checks++; if (n !== 10) begin failures++; $display("FAIL starve_timeout grants=%0d exp=10", n); end
        checks++; if (dual !== 0) begin failures++; $display("FAIL starve_dual_ack cycles=%0d exp=0", dual); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got[k] !== exp_i[k]) begin
                failures++; $display("FAIL starve_order k=%0d got_fetch=%0d exp_fetch=%0d", k, got[k], exp_i[k]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic en_exp, ack_exp;
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_be = 4'hF; ifa.d_addr = 32'h180;
        for (int c = 1; c <= 12; c++) begin
            tick();
            en_exp  = (c == 1 || c == 5 || c == 9);
            ack_exp = (c == 3 || c == 7 || c == 11);
            checks++;
            if (ifa.mem_en !== en_exp || ifa.d_ack !== ack_exp) begin
                failures++; $display("FAIL b2b c=%0d mem_en=%b d_ack=%b exp=%b,%b", c, ifa.mem_en, ifa.d_ack, en_exp, ack_exp);
            end
            if (c == 11) ifa.d_req = 0;
        end
        tick();
    endtask

    task automatic test_mem_lat3;
        logic en_exp, busy_exp, ack_exp;
        ifb.d_req = 1; ifb.d_we = 0; ifb.d_be = 4'hF; ifb.d_addr = 32'h400;
        for (int c = 1; c <= 7; c++) begin
            tick();
            ifb.mem_rdata = (c == 4) ? 32'h12345678 : 32'hBAD0BAD0;
            en_exp   = (c == 1);
            busy_exp = (c >= 1 && c <= 5);
            ack_exp  = (c == 5);
            checks++;
            if (ifb.mem_en !== en_exp || ifb.busy !== busy_exp || ifb.d_ack !== ack_exp) begin
                failures++; $display("FAIL lat3 c=%0d mem_en=%b busy=%b d_ack=%b exp=%b,%b,%b",
                                     c, ifb.mem_en, ifb.busy, ifb.d_ack, en_exp, busy_exp, ack_exp);
            end
            if (c == 5) begin
                checks++;
                if (ifb.d_rdata !== 32'h12345678) begin
                    failures++; $display("FAIL lat3_rdata got=%h exp=12345678", ifb.d_rdata);
                end
                ifb.d_req = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_starvation();
        test_back_to_back();
        test_mem_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
